// File: rtl/axi_addr_remap.sv
// Rule-based AXI AW/AR address translation in front of axi_modify_address.
// Ports: clk_i/rst_i, rule_* table, slv_req_i/slv_resp_o, mst_req_o/mst_resp_i, {aw,ar}_{addr,miss}_o.
package axi_addr_remap_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] maddr_t;
  typedef logic [3:0]  id_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

// One-entry translate-and-hold register for a single address channel.
// Ports: slave valid/ready/chan/addr in, master valid/ready/chan/xaddr/miss out.
module axi_addr_remap_stage #(
  parameter int unsigned NumRules = 1,
  parameter type chan_t     = logic,
  parameter type slv_addr_t = logic,
  parameter type mst_addr_t = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumRules-1:0]       rule_en_i,
  input  slv_addr_t [NumRules-1:0]  rule_start_i,
  input  slv_addr_t [NumRules-1:0]  rule_end_i,
  input  mst_addr_t [NumRules-1:0]  rule_base_i,
  input  logic                      slv_valid_i,
  output logic                      slv_ready_o,
  input  chan_t                     slv_chan_i,
  input  slv_addr_t                 slv_addr_i,
  output logic                      mst_valid_o,
  input  logic                      mst_ready_i,
  output chan_t                     mst_chan_o,
  output mst_addr_t                 mst_addr_o,
  output logic                      mst_miss_o
);
  logic      valid_q, valid_d;
  chan_t     chan_q, chan_d;
  mst_addr_t addr_q, addr_d;
  logic      miss_q, miss_d;

  mst_addr_t xl;
  slv_addr_t off;
  logic      hit;
  logic      load;

  // Walk high to low so the lowest matching index is the last writer.
  always_comb begin
    xl  = mst_addr_t'(slv_addr_i);
    off = '0;
    hit = 1'b0;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (rule_en_i[i] &&
          slv_addr_i >= rule_start_i[i] &&
          slv_addr_i < rule_end_i[i]) begin
        off = slv_addr_i - rule_start_i[i];
        xl  = rule_base_i[i] + mst_addr_t'(off);
        hit = 1'b1;
      end
    end
  end

  // Held low in reset so nothing is accepted while state is cleared.
  assign slv_ready_o = !rst_i && (!valid_q || mst_ready_i);
  assign load        = slv_valid_i && slv_ready_o;

  always_comb begin
    valid_d = valid_q;
    chan_d  = chan_q;
    addr_d  = addr_q;
    miss_d  = miss_q;
    if (load) begin
      valid_d = 1'b1;
      chan_d  = slv_chan_i;
      addr_d  = xl;
      miss_d  = !hit;
    end else if (mst_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      chan_q  <= '0;
      addr_q  <= '0;
      miss_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      chan_q  <= chan_d;
      addr_q  <= addr_d;
      miss_q  <= miss_d;
    end
  end

  assign mst_valid_o = valid_q;
  assign mst_chan_o  = chan_q;
  assign mst_addr_o  = addr_q;
  assign mst_miss_o  = miss_q;
endmodule

// Top: AW/AR go through translate-and-hold stages; W/B/R are wired through.
// Translated addresses appear on aw_addr_o/ar_addr_o; mst_req_o keeps slave addr.
module axi_addr_remap
  import axi_addr_remap_pkg::*;
#(
  parameter int unsigned NumRules = 1,
  parameter type slv_addr_t = axi_addr_remap_pkg::addr_t,
  parameter type mst_addr_t = axi_addr_remap_pkg::maddr_t,
  parameter type aw_chan_t  = axi_addr_remap_pkg::aw_chan_t,
  parameter type ar_chan_t  = axi_addr_remap_pkg::ar_chan_t,
  parameter type req_t      = axi_addr_remap_pkg::req_t,
  parameter type resp_t     = axi_addr_remap_pkg::resp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumRules-1:0]       rule_en_i,
  input  slv_addr_t [NumRules-1:0]  rule_start_i,
  input  slv_addr_t [NumRules-1:0]  rule_end_i,
  input  mst_addr_t [NumRules-1:0]  rule_base_i,
  input  req_t                      slv_req_i,
  output resp_t                     slv_resp_o,
  output req_t                      mst_req_o,
  input  resp_t                     mst_resp_i,
  output mst_addr_t                 aw_addr_o,
  output mst_addr_t                 ar_addr_o,
  output logic                      aw_miss_o,
  output logic                      ar_miss_o
);
  logic     aw_rdy, ar_rdy;
  logic     aw_vld, ar_vld;
  aw_chan_t aw_chan;
  ar_chan_t ar_chan;

  axi_addr_remap_stage #(
    .NumRules   (NumRules),
    .chan_t     (aw_chan_t),
    .slv_addr_t (slv_addr_t),
    .mst_addr_t (mst_addr_t)
  ) i_aw (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rule_en_i    (rule_en_i),
    .rule_start_i (rule_start_i),
    .rule_end_i   (rule_end_i),
    .rule_base_i  (rule_base_i),
    .slv_valid_i  (slv_req_i.aw_valid),
    .slv_ready_o  (aw_rdy),
    .slv_chan_i   (slv_req_i.aw),
    .slv_addr_i   (slv_req_i.aw.addr),
    .mst_valid_o  (aw_vld),
    .mst_ready_i  (mst_resp_i.aw_ready),
    .mst_chan_o   (aw_chan),
    .mst_addr_o   (aw_addr_o),
    .mst_miss_o   (aw_miss_o)
  );

  axi_addr_remap_stage #(
    .NumRules   (NumRules),
    .chan_t     (ar_chan_t),
    .slv_addr_t (slv_addr_t),
    .mst_addr_t (mst_addr_t)
  ) i_ar (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rule_en_i    (rule_en_i),
    .rule_start_i (rule_start_i),
    .rule_end_i   (rule_end_i),
    .rule_base_i  (rule_base_i),
    .slv_valid_i  (slv_req_i.ar_valid),
    .slv_ready_o  (ar_rdy),
    .slv_chan_i   (slv_req_i.ar),
    .slv_addr_i   (slv_req_i.ar.addr),
    .mst_valid_o  (ar_vld),
    .mst_ready_i  (mst_resp_i.ar_ready),
    .mst_chan_o   (ar_chan),
    .mst_addr_o   (ar_addr_o),
    .mst_miss_o   (ar_miss_o)
  );

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_chan;
    mst_req_o.aw_valid = aw_vld;
    mst_req_o.ar       = ar_chan;
    mst_req_o.ar_valid = ar_vld;
  end

  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = aw_rdy;
    slv_resp_o.ar_ready = ar_rdy;
  end
endmodule

// File: tb/tb_axi_addr_remap.sv
// Directed + random bench for axi_addr_remap against a queue-based model.
// Model translates at acceptance time using first-match rule arithmetic.
module tb_axi_addr_remap;
  import axi_addr_remap_pkg::*;

  localparam int NR = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        ren;
  logic [NR-1:0][31:0]  rs, re, rb;
  req_t                 sreq, mreq;
  resp_t                sresp, mresp;
  logic [31:0]          awa, ara;
  logic                 awm, arm;

  int nvec = 0;
  int nerr = 0;
  int hs_aw = 0;
  int h;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] x;
    logic        miss;
  } beat_t;

  beat_t qaw[$];
  beat_t qar[$];

  always #5 clk = ~clk;

  axi_addr_remap #(.NumRules(NR)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rule_en_i    (ren),
    .rule_start_i (rs),
    .rule_end_i   (re),
    .rule_base_i  (rb),
    .slv_req_i    (sreq),
    .slv_resp_o   (sresp),
    .mst_req_o    (mreq),
    .mst_resp_i   (mresp),
    .aw_addr_o    (awa),
    .ar_addr_o    (ara),
    .aw_miss_o    (awm),
    .ar_miss_o    (arm)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t model(input logic [3:0] id,
                                  input logic [31:0] a,
                                  input logic [7:0] len);
    beat_t b;
    b.id   = id;
    b.addr = a;
    b.len  = len;
    b.x    = a;
    b.miss = 1'b1;
    for (int i = 0; i < NR; i++) begin
      if (ren[i] && a >= rs[i] && a < re[i]) begin
        b.x    = rb[i] + (a - rs[i]);
        b.miss = 1'b0;
        break;
      end
    end
    return b;
  endfunction

  task automatic tick();
    logic ra, rr;
    @(negedge clk);
    ra = !rst && (qaw.size() == 0 || mresp.aw_ready);
    rr = !rst && (qar.size() == 0 || mresp.ar_ready);
    chk("aw_ready", 64'(sresp.aw_ready), 64'(ra));
    chk("ar_ready", 64'(sresp.ar_ready), 64'(rr));
    chk("aw_valid", 64'(mreq.aw_valid), 64'(qaw.size() != 0));
    chk("ar_valid", 64'(mreq.ar_valid), 64'(qar.size() != 0));
    if (qaw.size() != 0) begin
      chk("aw_addr_o", 64'(awa), 64'(qaw[0].x));
      chk("aw_miss_o", 64'(awm), 64'(qaw[0].miss));
      chk("aw.addr", 64'(mreq.aw.addr), 64'(qaw[0].addr));
      chk("aw.id", 64'(mreq.aw.id), 64'(qaw[0].id));
      chk("aw.len", 64'(mreq.aw.len), 64'(qaw[0].len));
    end
    if (qar.size() != 0) begin
      chk("ar_addr_o", 64'(ara), 64'(qar[0].x));
      chk("ar_miss_o", 64'(arm), 64'(qar[0].miss));
      chk("ar.addr", 64'(mreq.ar.addr), 64'(qar[0].addr));
      chk("ar.id", 64'(mreq.ar.id), 64'(qar[0].id));
    end
    chk("w_valid pass", 64'(mreq.w_valid), 64'(sreq.w_valid));
    chk("w data pass", 64'(mreq.w.data), 64'(sreq.w.data));
    chk("r_valid pass", 64'(sresp.r_valid), 64'(mresp.r_valid));
    chk("w_ready pass", 64'(sresp.w_ready), 64'(mresp.w_ready));
    if (mreq.aw_valid && mresp.aw_ready) hs_aw++;
    if (rst) begin
      qaw.delete();
      qar.delete();
    end else begin
      if (qaw.size() != 0 && mresp.aw_ready) void'(qaw.pop_front());
      if (qar.size() != 0 && mresp.ar_ready) void'(qar.pop_front());
      if (sreq.aw_valid && ra)
        qaw.push_back(model(sreq.aw.id, sreq.aw.addr, sreq.aw.len));
      if (sreq.ar_valid && rr)
        qar.push_back(model(sreq.ar.id, sreq.ar.addr, sreq.ar.len));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    sreq = '0;
    mresp = '0;
    ren = '0;
    rs = '0;
    re = '0;
    rb = '0;
    mresp.aw_ready = 1'b1;
    mresp.ar_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst aw_valid", 64'(mreq.aw_valid), 64'(0));
    chk("rst ar_valid", 64'(mreq.ar_valid), 64'(0));
    chk("rst aw_addr_o", 64'(awa), 64'(0));
    chk("rst ar_addr_o", 64'(ara), 64'(0));
    chk("rst aw_miss", 64'(awm), 64'(0));
    chk("rst ar_miss", 64'(arm), 64'(0));
    chk("rst aw_ready", 64'(sresp.aw_ready), 64'(1));
    chk("rst ar_ready", 64'(sresp.ar_ready), 64'(1));

    // basic translation
    ren = 4'b0001;
    rs[0] = 32'h1000;
    re[0] = 32'h2000;
    rb[0] = 32'h8000_0000;
    sreq.aw.id = 4'd5;
    sreq.aw.len = 8'd3;
    sreq.aw.addr = 32'h1234;
    sreq.aw_valid = 1'b1;
    tick();
    sreq.aw_valid = 1'b0;
    chk("basic xlate", 64'(awa), 64'h8000_0234);
    chk("basic miss", 64'(awm), 64'(0));
    chk("basic orig addr", 64'(mreq.aw.addr), 64'h1234);
    chk("basic id", 64'(mreq.aw.id), 64'(5));
    chk("basic len", 64'(mreq.aw.len), 64'(3));
    tick();

    // overlap: lowest index wins
    ren = 4'b0011;
    rs[0] = 32'h0;
    re[0] = 32'h4000;
    rb[0] = 32'hA000;
    rs[1] = 32'h1000;
    re[1] = 32'h2000;
    rb[1] = 32'hB000;
    sreq.ar.id = 4'd2;
    sreq.ar.addr = 32'h1800;
    sreq.ar_valid = 1'b1;
    tick();
    sreq.ar_valid = 1'b0;
    chk("overlap xlate", 64'(ara), 64'hB800);
    chk("overlap miss", 64'(arm), 64'(0));
    tick();

    // all rules disabled
    ren = 4'b0000;
    sreq.ar.addr = 32'h1234;
    sreq.ar_valid = 1'b1;
    tick();
    sreq.ar_valid = 1'b0;
    chk("miss addr", 64'(ara), 64'h1234);
    chk("miss flag", 64'(arm), 64'(1));
    tick();

    // backpressure with rule churn
    ren = 4'b0001;
    rs[0] = 32'h1000;
    re[0] = 32'h2000;
    rb[0] = 32'h8000_0000;
    mresp.aw_ready = 1'b0;
    sreq.aw.addr = 32'h1500;
    sreq.aw_valid = 1'b1;
    tick();
    sreq.aw.addr = 32'h1600;
    h = hs_aw;
    for (int k = 0; k < 5; k++) begin
      rb[0] = 32'h9000_0000 + 32'(k) * 32'h0100_0000;
      tick();
      chk("bp hold addr", 64'(awa), 64'h8000_0500);
      chk("bp slv ready", 64'(sresp.aw_ready), 64'(0));
    end
    chk("bp no hs", 64'(hs_aw - h), 64'(0));
    mresp.aw_ready = 1'b1;
    tick();
    sreq.aw_valid = 1'b0;
    chk("bp one hs", 64'(hs_aw - h), 64'(1));
    chk("bp next beat", 64'(awa), 64'h9400_0600);
    tick();

    // streaming 16 beats
    rb[0] = 32'h8000_0000;
    h = hs_aw;
    for (int i = 0; i < 16; i++) begin
      sreq.aw.addr = 32'h1000 + 32'(i) * 32'h10;
      sreq.aw.id = 4'(i);
      sreq.aw_valid = 1'b1;
      tick();
    end
    sreq.aw_valid = 1'b0;
    tick();
    chk("stream beats", 64'(hs_aw - h), 64'(16));

    // reset while holding a beat
    mresp.aw_ready = 1'b0;
    sreq.aw.addr = 32'h1100;
    sreq.aw_valid = 1'b1;
    tick();
    sreq.aw_valid = 1'b0;
    chk("pre-rst valid", 64'(mreq.aw_valid), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid-rst valid", 64'(mreq.aw_valid), 64'(0));
    chk("mid-rst addr", 64'(awa), 64'(0));
    mresp.aw_ready = 1'b1;
    sreq.aw.addr = 32'h1ABC;
    sreq.aw_valid = 1'b1;
    tick();
    sreq.aw_valid = 1'b0;
    chk("post-rst xlate", 64'(awa), 64'h8000_0ABC);
    tick();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) begin
        for (int i = 0; i < NR; i++) begin
          ren[i] = ($urandom_range(0, 3) != 0);
          rs[i] = $urandom_range(0, 15) << 12;
          re[i] = $urandom_range(0, 16) << 12;
          rb[i] = $urandom;
        end
      end
      if (c % 7 == 3) rb[$urandom_range(0, NR - 1)] = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      sreq.aw_valid = ($urandom_range(0, 3) != 0);
      sreq.aw.addr = $urandom_range(0, 32'h11000);
      sreq.aw.id = 4'($urandom);
      sreq.aw.len = 8'($urandom);
      sreq.ar_valid = ($urandom_range(0, 3) != 0);
      sreq.ar.addr = $urandom_range(0, 32'h11000);
      sreq.ar.id = 4'($urandom);
      sreq.ar.len = 8'($urandom);
      sreq.w_valid = ($urandom_range(0, 1) != 0);
      sreq.w.data = $urandom;
      mresp.aw_ready = ($urandom_range(0, 2) != 0);
      mresp.ar_ready = ($urandom_range(0, 2) != 0);
      mresp.w_ready = ($urandom_range(0, 1) != 0);
      mresp.r_valid = ($urandom_range(0, 1) != 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/axi_addr_remap.md
# axi_addr_remap

Rule-based address translation stage placed directly upstream of `axi_modify_address`. It takes AW and AR beats through one-entry pipeline registers and computes a translated master-side address for each beat from a runtime rule table. The registered address is presented as `aw_addr_o` / `ar_addr_o`, which stay stable for as long as the corresponding valid is asserted. W, B and R pass through combinationally.

## Interface
Parameters:
- `NumRules`, 1: number of translation rules; must be ≥1.
- `slv_addr_t`, logic: slave-side address type.
- `mst_addr_t`, logic: master-side address type.
- `req_t`, logic: AXI request struct, slave-side address width, used on both ports.
- `resp_t`, logic: AXI response struct.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. **One clock; reset is synchronous and active-high.**
- `rule_en_i`, in, NumRules: per-rule enable.
- `rule_start_i`, in, NumRules×slv_addr_t: inclusive region start.
- `rule_end_i`, in, NumRules×slv_addr_t: exclusive region end.
- `rule_base_i`, in, NumRules×mst_addr_t: translated base address.
- `slv_req_i`, in, req_t: upstream request.
- `slv_resp_o`, out, resp_t: upstream response.
- `mst_req_o`, out, req_t: request toward `axi_modify_address`. AW/AR are registered; `addr` carries the original slave address.
- `mst_resp_i`, in, resp_t: downstream response.
- `aw_addr_o`, out, mst_addr_t: translated AW address; stable while `mst_req_o.aw_valid`.
- `ar_addr_o`, out, mst_addr_t: translated AR address; stable while `mst_req_o.ar_valid`.
- `aw_miss_o`, out, 1: registered beat matched no rule; valid with `aw_valid`.
- `ar_miss_o`, out, 1: same as `aw_miss_o`, for AR.

## Operation
- AW and AR are handled by identical, independent pipeline registers. Each holds: valid_q, chan_q, addr_q, miss_q.
- Slave ready: `slv_resp_o.aw_ready = !valid_q || mst_resp_i.aw_ready`. Same form for AR.
- Load on a slave handshake:
  - chan_q ← slave channel, unmodified.
  - addr_q ← translated address.
  - miss_q ← no-match flag.
  - valid_q ← 1.
- Unload on a master handshake without a load in the same cycle: valid_q ← 0. Data registers hold their value.
- Rule match for rule i: `rule_en_i[i] && start ≤ addr && addr < end`, unsigned compare. A rule with start ≥ end never matches.
- Multiple matches: the lowest index wins.
- On a match, translated = `rule_base_i[i] + (addr − rule_start_i[i])`:
  - The offset is computed in slv_addr_t width.
  - It is then zero-extended or truncated to mst_addr_t.
  - The sum wraps modulo 2^|mst_addr_t|.
- On no match, translated = addr zero-extended or truncated to mst_addr_t, and miss = 1.
- Rules are sampled only in the slave-handshake cycle. Rule changes never alter a held beat.
- `mst_req_o`:
  - AW/AR channels and valids come from the registers.
  - W, w_valid, b_ready and r_ready pass straight from `slv_req_i`.
- `slv_resp_o`:
  - aw_ready and ar_ready are as defined above.
  - w_ready, b, b_valid, r and r_valid pass straight from `mst_resp_i`.
- W may reach downstream before its AW. This is AXI-legal and is not prevented.

## Timing
- Reset values:
  - valid_q = 0 and miss_q = 0 on both channels.
  - chan_q = '0 and addr_q = '0.
  - `aw_addr_o` = `ar_addr_o` = 0.
  - `mst_req_o.aw_valid` = `ar_valid` = 0.
  - `aw_ready` / `ar_ready` = 1 once reset is deasserted.
- Reset is also asserted as ready = 0 during `rst_i`: no beat is accepted while reset is high.
- Latency: an AW/AR beat accepted in cycle n is valid downstream in cycle n+1.
- Throughput: 1 beat/cycle per channel. A load and an unload in the same cycle replace the held beat with no bubble.
- Backpressure: while valid_q=1 and ready=0 downstream, all registered outputs hold and `slv_*_ready`=0.
- Reset mid-operation drops the held beat. Upstream and downstream are reset together.
- W/B/R paths are combinational and have zero latency.
- The ready path is combinational from `mst_resp_i` to `slv_resp_o`. Valid and data paths are registered.

## Test plan
- Setup for the scenarios below: rule0 = [0x1000,0x2000)→0x8000_0000, enabled. AW at 0x1234 → one cycle later `aw_addr_o`=0x8000_0234, `aw_miss_o`=0, and `mst_req_o.aw.addr`=0x1234 with id/len unchanged.
- Overlap: rule0 = [0x0,0x4000)→0xA000, rule1 = [0x1000,0x2000)→0xB000. AR at 0x1800 → `ar_addr_o`=0xA000 + 0x1800 = 0xB800, i.e. rule0 wins by lowest index.
- Miss and disabled rule: rule_en=0, AR at 0x1234 → `ar_addr_o`=0x1234, `ar_miss_o`=1.
- Backpressure and stability: hold `mst_resp_i.aw_ready`=0 for 5 cycles and change rule_base each cycle → `aw_addr_o` is constant and `slv aw_ready`=0. Release → exactly one handshake.
- Streaming: 16 back-to-back AW with `aw_ready`=1 continuously → 16 beats in 17 cycles, in order, with correct translation.
- Reset mid-beat: valid_q=1 and assert `rst_i` for 1 cycle → next cycle `aw_valid`=0 and `aw_addr_o`=0. The first post-reset AW translates correctly.
